comm_uart_rx: RTL and testbench

- UART receive front-end inside comm_ic; directly upstream of the command/protocol core, which consumes received bytes.
- Synchronises the serial input and deframes 8-bit characters: 1 start bit, 8 data bits LSB-first, optional even parity, 1 stop bit.
- Buffers accepted bytes in a small FIFO with a valid/ready output and reports framing, parity and overrun errors as single-cycle pulses.

---
 rtl/comm_uart_rx.sv | 107 ++++++++++
 tb/tb_comm_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/comm_uart_rx.sv
// comm_uart_rx: 8N1/8E1 UART receiver with 2-flop synchroniser, byte FIFO and error pulses
module comm_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
   state_t state, state_d;
   logic rx_m, rx_s;
   logic [TW-1:0] timer, timer_d;
   logic [2:0] cnt, cnt_d;
   logic [7:0] sh, sh_d;
   logic par_bad, par_d;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic tick, stop_hit, full, pop, push;
   assign tick = timer == '0;
   assign stop_hit = state == STOP && tick;
   assign full = count == (AW+1)'(FIFO_DEPTH);
   assign pop = out_valid & out_ready;
   assign push = stop_hit & rx_s & ~par_bad & (~full | pop);
   assign out_valid = count != '0;
   assign out_data = out_valid ? mem[rptr] : 8'h00;
   assign busy = state != IDLE;
   always_comb begin
      state_d = state;
      timer_d = tick ? timer : timer - 1'b1;
      cnt_d = cnt;
      sh_d = sh;
      par_d = par_bad;
      case (state)
         IDLE: if (!rx_s) begin
            state_d = START;
            timer_d = TW'(CLKS_PER_BIT/2 - 1);
         end
         START: if (tick) begin
            state_d = rx_s ? IDLE : DATA;
            timer_d = TW'(CLKS_PER_BIT - 1);
            cnt_d = 3'd0;
            par_d = 1'b0;
         end
         DATA: if (tick) begin
            sh_d = {rx_s, sh[7:1]};
            timer_d = TW'(CLKS_PER_BIT - 1);
            cnt_d = cnt + 1'b1;
            if (cnt == 3'd7) state_d = PARITY_EN != 0 ? PARITY : STOP;
         end
         PARITY: if (tick) begin
            par_d = ^{sh, rx_s};
            timer_d = TW'(CLKS_PER_BIT - 1);
            state_d = STOP;
         end
         STOP: if (tick) state_d = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         timer <= '0;
         cnt <= 3'd0;
         sh <= 8'h00;
         par_bad <= 1'b0;
         frame_err <= 1'b0;
         parity_err <= 1'b0;
         overrun <= 1'b0;
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         state <= state_d;
         timer <= timer_d;
         cnt <= cnt_d;
         sh <= sh_d;
         par_bad <= par_d;
         frame_err <= stop_hit & ~rx_s;
         parity_err <= stop_hit & rx_s & par_bad;
         overrun <= stop_hit & rx_s & ~par_bad & full & ~pop;
         wptr <= push ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
         count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
      end
   end
   // storage is not reset; out_data is masked to 0 while empty
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= sh;
   end
endmodule

// File: tb/tb_comm_uart_rx.sv
// tb_comm_uart_rx: directed table + sequences for comm_uart_rx, 8N1 and 8E1 instances
module tb_comm_uart_rx;
   logic clk = 0, rst = 1, line = 1, ready = 1, sel = 0;
   logic rx0, rx1;
   logic [7:0] d0, d1;
   logic v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;
   int checks = 0, passes = 0;
   int nfe = 0, npe = 0, nov = 0;
   logic [7:0] q[$];
   always #5 clk = ~clk;
   assign rx0 = sel ? 1'b1 : line;
   assign rx1 = sel ? line : 1'b1;
   comm_uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .rx(rx0), .out_data(d0), .out_valid(v0), .out_ready(ready),
      .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0));
   comm_uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst), .rx(rx1), .out_data(d1), .out_valid(v1), .out_ready(ready),
      .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1));
   wire m_valid = sel ? v1 : v0;
   wire [7:0] m_data = sel ? d1 : d0;
   wire m_busy = sel ? b1 : b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && ready) q.push_back(m_data);
         if (sel ? fe1 : fe0) nfe++;
         if (sel ? pe1 : pe0) npe++;
         if (sel ? ov1 : ov0) nov++;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask
   task automatic clr();
      q.delete();
      nfe = 0;
      npe = 0;
      nov = 0;
   endtask
   // line is left at the stop level; callers restore idle when stop = 0
   task automatic send(input logic [7:0] d, input bit pe, input bit pb, input bit stop);
      line = 0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         line = d[i];
         tick(16);
      end
      if (pe) begin
         line = pb;
         tick(16);
      end
      line = stop;
      tick(16);
   endtask
   typedef struct {
      bit s;
      logic [7:0] d;
      bit pb;
      bit stop;
      int np;
      logic [7:0] ed;
      int fe;
      int pe;
   } vec_t;
   vec_t tv[8];
   initial begin
      tv[0] = '{0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
      tv[1] = '{0, 8'h3C, 0, 1, 1, 8'h3C, 0, 0};
      tv[2] = '{0, 8'hFF, 0, 0, 0, 8'h00, 1, 0};
      tv[3] = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0};
      tv[4] = '{1, 8'h07, 0, 1, 0, 8'h00, 0, 1};
      tv[5] = '{1, 8'h5A, 0, 1, 1, 8'h5A, 0, 0};
      tv[6] = '{1, 8'h80, 0, 1, 0, 8'h00, 0, 1};
      tv[7] = '{1, 8'hC3, 0, 0, 0, 8'h00, 1, 0};
      tick(4);
      chk("rst_valid", {v0, v1}, 2'b00);
      chk("rst_data", {d0, d1}, 16'h0000);
      chk("rst_busy", {b0, b1}, 2'b00);
      chk("rst_err", {fe0, pe0, ov0, fe1, pe1, ov1}, 6'd0);
      rst = 0;
      tick(5);
      for (int i = 0; i < 8; i++) begin
         sel = tv[i].s;
         tick(2);
         clr();
         send(tv[i].d, tv[i].s, tv[i].pb, tv[i].stop);
         line = 1;
         tick(30);
         chk($sformatf("v%0d_pushes", i), q.size(), tv[i].np);
         if (tv[i].np == 1 && q.size() == 1) chk($sformatf("v%0d_data", i), q[0], tv[i].ed);
         chk($sformatf("v%0d_ferr", i), nfe, tv[i].fe);
         chk($sformatf("v%0d_perr", i), npe, tv[i].pe);
         chk($sformatf("v%0d_ovr", i), nov, 0);
         chk($sformatf("v%0d_busy", i), m_busy, 0);
      end
      // back-to-back frames held in the FIFO, then drained in order
      sel = 0;
      ready = 0;
      tick(2);
      clr();
      send(8'h00, 0, 0, 1);
      send(8'hFF, 0, 0, 1);
      send(8'h3C, 0, 0, 1);
      tick(10);
      chk("b2b_held", m_valid, 1);
      chk("b2b_none_popped", q.size(), 0);
      ready = 1;
      tick(10);
      chk("b2b_count", q.size(), 3);
      if (q.size() == 3) chk("b2b_order", {q[0], q[1], q[2]}, 24'h00FF3C);
      chk("b2b_empty", m_valid, 0);
      // 4-cycle glitch is a false start
      clr();
      line = 0;
      tick(4);
      line = 1;
      tick(3);
      chk("glitch_busy_seen", m_busy, 1);
      tick(40);
      chk("glitch_busy", m_busy, 0);
      chk("glitch_push", q.size(), 0);
      chk("glitch_err", nfe + npe + nov, 0);
      // stop bit low then a stuck-low line
      clr();
      send(8'h12, 0, 0, 0);
      tick(40);
      chk("brk_ferr", nfe, 1);
      chk("brk_wait", m_busy, 1);
      chk("brk_push", q.size(), 0);
      line = 1;
      tick(10);
      chk("brk_idle", m_busy, 0);
      send(8'h55, 0, 0, 1);
      tick(20);
      chk("brk_next", q.size() == 1 ? q[0] : 8'hEE, 8'h55);
      chk("brk_ferr_once", nfe, 1);
      // overrun on the fifth byte into a depth-4 FIFO
      ready = 0;
      tick(2);
      clr();
      for (int i = 1; i <= 5; i++) send(8'(i), 0, 0, 1);
      tick(20);
      chk("ovr_pulse", nov, 1);
      chk("ovr_ferr", nfe, 0);
      ready = 1;
      tick(10);
      chk("ovr_count", q.size(), 4);
      if (q.size() == 4) chk("ovr_order", {q[0], q[1], q[2], q[3]}, 32'h01020304);
      // reset during data bit 3 of a parity frame
      sel = 1;
      ready = 0;
      tick(2);
      clr();
      send(8'h07, 1, 1, 1);
      tick(10);
      chk("mid_prefill", m_valid, 1);
      line = 0;
      tick(16);
      for (int i = 0; i < 3; i++) begin
         line = 1'b1;
         tick(16);
      end
      line = 0;
      tick(8);
      rst = 1;
      line = 1;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_busy", m_busy, 0);
      chk("mid_rst_data", m_data, 8'h00);
      tick(3);
      rst = 0;
      ready = 1;
      tick(20);
      clr();
      send(8'h5A, 1, 0, 1);
      tick(20);
      chk("mid_next_count", q.size(), 1);
      chk("mid_next_data", q.size() == 1 ? q[0] : 8'hEE, 8'h5A);
      chk("mid_next_err", nfe + npe + nov, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
